color_detect_param: RTL and testbench



---
 rtl/color_detect_pkg.sv | 22 ++
 rtl/cs_edge_counter.sv | 35 +++
 rtl/color_detect_param.sv | 138 +++++++++++++
 tb/tb_color_detect_param.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/color_detect_pkg.sv
// Shared codes and FSM state type for the TCS3200 colour detector.
package color_detect_pkg;

  localparam logic [1:0] FLT_RED   = 2'd0;
  localparam logic [1:0] FLT_BLUE  = 2'd1;
  localparam logic [1:0] FLT_CLEAR = 2'd2;
  localparam logic [1:0] FLT_GREEN = 2'd3;

  localparam logic [1:0] COL_NONE  = 2'd0;
  localparam logic [1:0] COL_RED   = 2'd1;
  localparam logic [1:0] COL_GREEN = 2'd2;
  localparam logic [1:0] COL_BLUE  = 2'd3;

  typedef enum logic [2:0] {
    StIdle,
    StGreen,
    StRed,
    StBlue,
    StDecide
  } state_e;

endpackage

// File: rtl/cs_edge_counter.sv
// Synchronises the sensor frequency output and counts its rising edges into a
// saturating counter shared by all colour channels.
module cs_edge_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_1MHz,
  input  logic             rst,
  input  logic             cs_out,
  input  logic             clear,
  input  logic             gate,
  output logic [CNT_W-1:0] count
);

  // [1:0] is the two-flop synchroniser, [2] the previous synchronised level.
  logic [2:0] sync_q;
  logic       hit;

  assign hit = gate & sync_q[1] & ~sync_q[2];

  always_ff @(posedge clk_1MHz) begin
    if (rst) begin
      sync_q <= '0;
      count  <= '0;
    end else begin
      sync_q <= {sync_q[1:0], cs_out};
      // An edge landing on the clearing cycle belongs to the new window.
      if (clear) begin
        count <= CNT_W'(hit);
      end else if (hit && (count != '1)) begin
        count <= count + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/color_detect_param.sv
// Colour detector: steps the filter through GREEN, RED, BLUE windows, counts sensor
// edges per window and classifies the dominant colour in a one-cycle DECIDE slot.
module color_detect_param
  import color_detect_pkg::*;
#(
  parameter int unsigned WIN_CYCLES    = 500,
  parameter int unsigned SETTLE_CYCLES = 0,
  parameter int unsigned CNT_W         = 16,
  parameter int unsigned MIN_COUNT     = 8,
  parameter int unsigned MARGIN        = 4,
  parameter logic [1:0]  SCALE         = 2'b11
) (
  input  logic             clk_1MHz,
  input  logic             rst,
  input  logic             cs_out,
  input  logic             en,
  output logic [1:0]       filter,
  output logic [1:0]       scale,
  output logic [1:0]       color,
  output logic             color_valid,
  output logic [CNT_W-1:0] red_count,
  output logic [CNT_W-1:0] green_count,
  output logic [CNT_W-1:0] blue_count
);

  localparam int unsigned WinW = (WIN_CYCLES > 1) ? $clog2(WIN_CYCLES) : 1;

  state_e           state;
  logic [WinW-1:0]  win_cnt;
  logic [CNT_W-1:0] chan_cnt;
  logic [CNT_W-1:0] green_cap;
  logic [CNT_W-1:0] red_cap;
  logic             in_window;
  logic             win_first;
  logic             win_last;
  logic             gate;

  assign scale     = SCALE;
  assign in_window = (state == StGreen) || (state == StRed) || (state == StBlue);
  assign win_first = (win_cnt == '0);
  assign win_last  = (win_cnt == WinW'(WIN_CYCLES - 1));
  assign gate      = in_window && (win_cnt >= WinW'(SETTLE_CYCLES));

  cs_edge_counter #(
    .CNT_W (CNT_W)
  ) u_edge_counter (
    .clk_1MHz (clk_1MHz),
    .rst      (rst),
    .cs_out   (cs_out),
    .clear    (in_window && win_first),
    .gate     (gate),
    .count    (chan_cnt)
  );

  function automatic logic [1:0] classify(input logic [CNT_W-1:0] r, input logic [CNT_W-1:0] g,
                                          input logic [CNT_W-1:0] b);
    logic [CNT_W-1:0] top;
    logic [CNT_W-1:0] second;
    logic [1:0]       code;
    if (r >= g && r >= b) begin
      top    = r;
      second = (g > b) ? g : b;
      code   = COL_RED;
    end else if (g >= b) begin
      top    = g;
      second = (r > b) ? r : b;
      code   = COL_GREEN;
    end else begin
      top    = b;
      second = (r > g) ? r : g;
      code   = COL_BLUE;
    end
    if (32'(top) < MIN_COUNT) return COL_NONE;
    if (32'(top - second) < MARGIN) return COL_NONE;
    return code;
  endfunction

  // The shared counter still holds the previous window's total during the first
  // cycle of the next window, so each total is captured there (blue in DECIDE).
  always_ff @(posedge clk_1MHz) begin
    color_valid <= 1'b0;
    if (rst) begin
      state       <= StIdle;
      filter      <= FLT_CLEAR;
      win_cnt     <= '0;
      color       <= COL_NONE;
      red_count   <= '0;
      green_count <= '0;
      blue_count  <= '0;
      green_cap   <= '0;
      red_cap     <= '0;
    end else begin
      if (in_window) win_cnt <= win_last ? '0 : win_cnt + WinW'(1);
      unique case (state)
        StIdle: begin
          if (en) begin
            state  <= StGreen;
            filter <= FLT_GREEN;
          end
        end
        StGreen: begin
          if (win_last) begin
            state  <= StRed;
            filter <= FLT_RED;
          end
        end
        StRed: begin
          if (win_first) green_cap <= chan_cnt;
          if (win_last) begin
            state  <= StBlue;
            filter <= FLT_BLUE;
          end
        end
        StBlue: begin
          if (win_first) red_cap <= chan_cnt;
          if (win_last) begin
            state  <= StDecide;
            filter <= FLT_CLEAR;
          end
        end
        StDecide: begin
          red_count   <= red_cap;
          green_count <= green_cap;
          blue_count  <= chan_cnt;
          color       <= classify(red_cap, green_cap, chan_cnt);
          color_valid <= 1'b1;
          state       <= en ? StGreen : StIdle;
          filter      <= en ? FLT_GREEN : FLT_CLEAR;
        end
        default: begin
          state  <= StIdle;
          filter <= FLT_CLEAR;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_color_detect_param.sv
// Bench for color_detect_param: a behavioural sensor answers the filter select with
// square waves; expected counts and colours come from window arithmetic.
module tb_color_detect_param;

  localparam int WIN   = 500;
  localparam int MIN_C = 8;
  localparam int MARG  = 4;
  localparam int MAX_A = 65535;
  localparam int MAX_B = 63;
  localparam int BIG   = 1 << 30;

  logic        clk_1MHz;
  logic        rst = 1'b1;
  logic        en_a = 1'b0, en_b = 1'b0;
  logic        cs_a = 1'b0, cs_b = 1'b0;
  logic [1:0]  filter_a, scale_a, color_a, filter_b, scale_b, color_b;
  logic        color_valid_a, color_valid_b;
  logic [15:0] red_count_a, green_count_a, blue_count_a;
  logic [5:0]  red_count_b, green_count_b, blue_count_b;

  color_detect_param u_dut_a (
    .clk_1MHz    (clk_1MHz),
    .rst         (rst),
    .cs_out      (cs_a),
    .en          (en_a),
    .filter      (filter_a),
    .scale       (scale_a),
    .color       (color_a),
    .color_valid (color_valid_a),
    .red_count   (red_count_a),
    .green_count (green_count_a),
    .blue_count  (blue_count_a)
  );

  color_detect_param #(
    .CNT_W         (6),
    .SETTLE_CYCLES (100)
  ) u_dut_b (
    .clk_1MHz    (clk_1MHz),
    .rst         (rst),
    .cs_out      (cs_b),
    .en          (en_b),
    .filter      (filter_b),
    .scale       (scale_b),
    .color       (color_b),
    .color_valid (color_valid_b),
    .red_count   (red_count_b),
    .green_count (green_count_b),
    .blue_count  (blue_count_b)
  );

  initial begin
    clk_1MHz = 1'b0;
    forever #5 clk_1MHz = ~clk_1MHz;
  end

  // Sensor period and burst limit per filter code (0 red, 1 blue, 2 clear, 3 green).
  int per_a[4], lim_a[4], per_b[4], lim_b[4];
  int n_checks = 0, n_pass = 0;
  int ex_r, ex_g, ex_b, ex_col, ex_tol;

  typedef struct packed {
    int pr; int pg; int pb;
    int er; int eg; int eb;
    int ecol; int tol;
  } vec_t;
  vec_t rows[5];

  function automatic logic lvl(input int p, input int lim, input int ph);
    if (p == 0 || ph >= lim) return 1'b0;
    return (ph % p) >= (p / 2);
  endfunction

  // Waveform phase restarts whenever the filter changes, like a real sensor.
  initial begin
    int ph_a, ph_b;
    logic [1:0] last_a, last_b;
    ph_a = 0; ph_b = 0; last_a = 2'd2; last_b = 2'd2;
    forever begin
      @(negedge clk_1MHz);
      if (filter_a != last_a) ph_a = 0; else ph_a++;
      if (filter_b != last_b) ph_b = 0; else ph_b++;
      last_a = filter_a;
      last_b = filter_b;
      cs_a = lvl(per_a[filter_a], lim_a[filter_a], ph_a);
      cs_b = lvl(per_b[filter_b], lim_b[filter_b], ph_b);
    end
  end

  // Rising edges inside [settle, WIN) of a window, saturated.
  function automatic int ideal(input int p, input int lim, input int settle, input int maxc);
    int n = 0;
    if (p > 0)
      for (int ph = settle; ph < WIN && ph < lim; ph++)
        if (ph % p == p / 2) n++;
    return (n > maxc) ? maxc : n;
  endfunction

  function automatic int ref_color(input int r, input int g, input int b);
    int c[3];
    int hi_i, second;
    c = '{r, g, b};
    hi_i = 0;
    for (int i = 1; i < 3; i++) if (c[i] > c[hi_i]) hi_i = i;
    second = -1;
    for (int i = 0; i < 3; i++) if (i != hi_i && c[i] > second) second = c[i];
    if (c[hi_i] < MIN_C) return 0;
    if (c[hi_i] - second < MARG) return 0;
    return hi_i + 1;
  endfunction

  task automatic chk(input string name, input int got, input int lo, input int hi);
    n_checks++;
    if (got >= lo && got <= hi) n_pass++;
    else $display("FAIL %s: got %0d, want %0d..%0d", name, got, lo, hi);
  endtask

  task automatic chk_cnt(input string name, input int got, input int e, input int tol,
                         input int maxc);
    chk(name, got, (e - tol < 0) ? 0 : e - tol, (e + tol > maxc) ? maxc : e + tol);
  endtask

  task automatic check_round(input string name, input int gr, input int gg, input int gb,
                             input int gc, input int er, input int eg, input int eb,
                             input int ec, input int tol);
    int want;
    bit stable;
    chk_cnt({name, " red"}, gr, er, tol, MAX_A);
    chk_cnt({name, " green"}, gg, eg, tol, MAX_A);
    chk_cnt({name, " blue"}, gb, eb, tol, MAX_A);
    if (ec >= 0) begin
      chk({name, " color"}, gc, ec, ec);
    end else begin
      // Only judge colour when no ±tol count jitter could change the verdict.
      want = ref_color(er, eg, eb);
      stable = 1'b1;
      for (int dr = -tol; dr <= tol; dr++)
        for (int dg = -tol; dg <= tol; dg++)
          for (int db = -tol; db <= tol; db++)
            if (ref_color((er + dr < 0) ? 0 : er + dr, (eg + dg < 0) ? 0 : eg + dg,
                          (eb + db < 0) ? 0 : eb + db) != want) stable = 1'b0;
      if (stable) chk({name, " color"}, gc, want, want);
    end
  endtask

  task automatic load(input int pr, input int pg, input int pb, input int ec, input int tol);
    per_a[0] = pr; per_a[3] = pg; per_a[1] = pb; per_a[2] = 0;
    ex_r = ideal(pr, BIG, 0, MAX_A);
    ex_g = ideal(pg, BIG, 0, MAX_A);
    ex_b = ideal(pb, BIG, 0, MAX_A);
    ex_col = ec;
    ex_tol = tol;
  endtask

  task automatic load_random();
    int p[3];
    for (int i = 0; i < 3; i++) p[i] = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(4, 40);
    load(p[0], p[1], p[2], -1, 1);
  endtask

  task automatic wait_valid_a(input bit timed, output int n);
    n = 0;
    while (n < 1700) begin
      @(posedge clk_1MHz); #1;
      n++;
      if (timed) begin
        if (n == 1)    chk("filter green entry", int'(filter_a), 3, 3);
        if (n == 500)  chk("filter green last", int'(filter_a), 3, 3);
        if (n == 501)  chk("filter red", int'(filter_a), 0, 0);
        if (n == 1001) chk("filter blue", int'(filter_a), 1, 1);
        if (n == 1501) chk("filter decide", int'(filter_a), 2, 2);
        if (n == 1502) chk("filter next green", int'(filter_a), 3, 3);
      end
      if (color_valid_a) break;
    end
  endtask

  task automatic wait_filter_a(input int f, input string name);
    int n = 0;
    while (n < 2000 && int'(filter_a) != f) begin
      @(posedge clk_1MHz); #1;
      n++;
    end
    chk(name, int'(filter_a), f, f);
  endtask

  task automatic finish_round(input string name, input int n, input int want_n);
    if (want_n > 0) chk({name, " latency"}, n, want_n, want_n);
    else chk({name, " valid"}, int'(color_valid_a), 1, 1);
    check_round(name, int'(red_count_a), int'(green_count_a), int'(blue_count_a),
                int'(color_a), ex_r, ex_g, ex_b, ex_col, ex_tol);
  endtask

  initial begin
    int n, bad;
    for (int i = 0; i < 4; i++) begin
      per_a[i] = 0; lim_a[i] = BIG; per_b[i] = 0; lim_b[i] = BIG;
    end
    rows[0] = '{4, 12, 12, 125, 42, 42, 1, 1};
    rows[1] = '{10, 5, 20, 50, 100, 25, 2, 1};
    rows[2] = '{10, 10, 4, 50, 50, 125, 3, 1};
    rows[3] = '{8, 8, 8, 62, 62, 62, 0, 1};
    rows[4] = '{0, 0, 0, 0, 0, 0, 0, 0};

    repeat (3) @(posedge clk_1MHz);
    #1;
    chk("rst filter", int'(filter_a), 2, 2);
    chk("rst color", int'(color_a), 0, 0);
    chk("rst valid", int'(color_valid_a), 0, 0);
    chk("rst counts", int'(red_count_a) + int'(green_count_a) + int'(blue_count_a), 0, 0);
    chk("scale", int'(scale_a), 3, 3);
    rst = 1'b0;
    @(posedge clk_1MHz); #1;
    chk("idle filter", int'(filter_a), 2, 2);

    // Directed rounds, back to back; the next row is loaded at each valid strobe.
    load(rows[0].pr, rows[0].pg, rows[0].pb, rows[0].ecol, rows[0].tol);
    ex_r = rows[0].er; ex_g = rows[0].eg; ex_b = rows[0].eb;
    en_a = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wait_valid_a(i == 0, n);
      finish_round($sformatf("row%0d", i), n, (i == 0) ? 1502 : 1501);
      if (i < 4) begin
        load(rows[i+1].pr, rows[i+1].pg, rows[i+1].pb, rows[i+1].ecol, rows[i+1].tol);
        ex_r = rows[i+1].er; ex_g = rows[i+1].eg; ex_b = rows[i+1].eb;
      end else begin
        load_random();
      end
    end

    for (int r = 0; r < 5; r++) begin
      wait_valid_a(1'b0, n);
      finish_round($sformatf("rand%0d", r), n, 1501);
      load_random();
    end

    // Reset in the middle of BLUE aborts the round; GREEN restarts once released.
    wait_filter_a(1, "reach blue");
    repeat (10) @(posedge clk_1MHz);
    #1;
    rst = 1'b1;
    @(posedge clk_1MHz); #1;
    chk("midrst filter", int'(filter_a), 2, 2);
    chk("midrst color", int'(color_a), 0, 0);
    chk("midrst valid", int'(color_valid_a), 0, 0);
    chk("midrst counts", int'(red_count_a) + int'(green_count_a) + int'(blue_count_a), 0, 0);
    rst = 1'b0;
    @(posedge clk_1MHz); #1;
    chk("restart green", int'(filter_a), 3, 3);
    wait_valid_a(1'b0, n);
    finish_round("after rst", n, 1501);
    load_random();

    // Dropping en during RED still completes the round, then parks in IDLE.
    wait_filter_a(0, "reach red");
    en_a = 1'b0;
    wait_valid_a(1'b0, n);
    finish_round("en drop", n, 0);
    chk("en drop idle filter", int'(filter_a), 2, 2);
    bad = 0;
    repeat (200) begin
      @(posedge clk_1MHz); #1;
      if (filter_a != 2'd2 || color_valid_a) bad++;
    end
    chk("idle held", bad, 0, 0);

    // Narrow counter with settle: red saturates, green burst lies in the settle span.
    per_b[0] = 2;
    per_b[3] = 4; lim_b[3] = 96;
    en_b = 1'b1;
    n = 0;
    while (n < 1700) begin
      @(posedge clk_1MHz); #1;
      n++;
      if (color_valid_b) break;
    end
    en_b = 1'b0;
    chk("sat latency", n, 1502, 1502);
    chk("sat red", int'(red_count_b), MAX_B, MAX_B);
    chk("settle green", int'(green_count_b), 0, 0);
    chk("sat blue", int'(blue_count_b), 0, 0);
    chk("sat color", int'(color_b), 1, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
